// File: rtl/hamming_encoder_stream.sv
// Streaming SECDED Hamming(8,4) encoder: one byte in, two codewords out over valid/ready,
// with optional one- or two-bit error injection applied as each codeword is loaded.
module hamming_encoder_stream #(
  parameter bit LOW_FIRST = 1'b1,
  parameter bit INJ_EN    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_code,
  output logic       out_valid,
  input  logic       out_ready,
  input  logic [1:0] inj_mode,
  input  logic [2:0] inj_pos,
  output logic [7:0] word_count,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, FIRST, SECOND} state_t;

  state_t     state;
  logic [3:0] pend_nib_p0;
  logic [3:0] first_nib;
  logic [3:0] second_nib;
  logic [7:0] mask;

  // Layout {p_all, d3, d2, d1, c2, d0, c1, c0}, even overall parity in bit 7.
  function automatic logic [7:0] encode(input logic [3:0] d);
    logic [6:0] c;
    c[0] = d[0] ^ d[1] ^ d[3];
    c[1] = d[0] ^ d[2] ^ d[3];
    c[2] = d[0];
    c[3] = d[1] ^ d[2] ^ d[3];
    c[4] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    return {^c, c};
  endfunction

  function automatic logic [7:0] inj_mask(input logic [1:0] mode, input logic [2:0] pos);
    logic [7:0] m;
    logic [2:0] pos_n;
    m     = '0;
    pos_n = pos + 3'd1;
    if (INJ_EN) begin
      case (mode)
        2'b01: m[pos] = 1'b1;
        2'b10: begin
          m[pos]   = 1'b1;
          m[pos_n] = 1'b1;
        end
        default: m = '0;
      endcase
    end
    return m;
  endfunction

  assign first_nib  = LOW_FIRST ? in_data[3:0] : in_data[7:4];
  assign second_nib = LOW_FIRST ? in_data[7:4] : in_data[3:0];
  assign mask       = inj_mask(inj_mode, inj_pos);
  assign in_ready   = (state == IDLE) || ((state == SECOND) && out_ready);

  // Stage p0: byte capture, codeword load and handshake bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      out_code    <= 8'h00;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      word_count  <= 8'h00;
      pend_nib_p0 <= 4'h0;
    end else begin
      if (out_valid && out_ready)
        word_count <= word_count + 8'd1;
      case (state)
        IDLE: begin
          if (in_valid) begin
            pend_nib_p0 <= second_nib;
            out_code    <= encode(first_nib) ^ mask;
            out_valid   <= 1'b1;
            busy        <= 1'b1;
            state       <= FIRST;
          end
        end
        FIRST: begin
          if (out_ready) begin
            out_code <= encode(pend_nib_p0) ^ mask;
            state    <= SECOND;
          end
        end
        SECOND: begin
          if (out_ready) begin
            if (in_valid) begin
              pend_nib_p0 <= second_nib;
              out_code    <= encode(first_nib) ^ mask;
              state       <= FIRST;
            end else begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_encoder_stream.sv
// Bench for hamming_encoder_stream: vector table, hand-written corner sequences and a
// randomized run against a positional-Hamming reference model.
module tb_hamming_encoder_stream;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [1:0] inj_mode = 2'b00;
  logic [2:0] inj_pos = 3'd0;

  logic       in_ready, out_valid, busy;
  logic [7:0] out_code, word_count;
  logic       h_in_ready, h_out_valid, h_busy;
  logic [7:0] h_out_code, h_word_count;

  int checks = 0;
  int failures = 0;

  hamming_encoder_stream #(.LOW_FIRST(1'b1), .INJ_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_code(out_code), .out_valid(out_valid), .out_ready(out_ready),
    .inj_mode(inj_mode), .inj_pos(inj_pos), .word_count(word_count), .busy(busy)
  );

  hamming_encoder_stream #(.LOW_FIRST(1'b0), .INJ_EN(1'b1)) dut_hf (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(h_in_ready),
    .out_code(h_out_code), .out_valid(h_out_valid), .out_ready(out_ready),
    .inj_mode(inj_mode), .inj_pos(inj_pos), .word_count(h_word_count), .busy(h_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Classic Hamming: data at non-power-of-two positions 3,5,6,7; parity at 2^k covers positions with bit k set.
  function automatic logic [7:0] ref_enc(input logic [3:0] d);
    logic [7:0] c;
    int dpos;
    logic p;
    c = '0;
    for (int i = 0; i < 4; i++) begin
      dpos = (i == 0) ? 3 : (i == 1) ? 5 : (i == 2) ? 6 : 7;
      c[dpos-1] = d[i];
    end
    for (int k = 0; k < 3; k++) begin
      p = 1'b0;
      for (int pos = 1; pos <= 7; pos++)
        if (((pos >> k) & 1) == 1) p ^= c[pos-1];
      c[(1 << k) - 1] = p;
    end
    c[7] = ^c[6:0];
    return c;
  endfunction

  function automatic logic [7:0] ref_mask(input logic [1:0] mode, input logic [2:0] pos);
    logic [7:0] m;
    m = '0;
    if (mode == 2'b01) m[pos] = 1'b1;
    if (mode == 2'b10) begin
      m[pos] = 1'b1;
      m[(int'(pos) + 1) % 8] = 1'b1;
    end
    return m;
  endfunction

  // 0 = clean, 1 = single error, 2 = double error
  function automatic int classify(input logic [7:0] code);
    int syn;
    syn = 0;
    for (int pos = 1; pos <= 7; pos++)
      if (code[pos-1]) syn ^= pos;
    if (^code) return 1;
    if (syn != 0) return 2;
    return 0;
  endfunction

  typedef struct {
    logic [7:0] din;
    logic [1:0] mode;
    logic [2:0] pos;
    logic [7:0] exp0, exp1;
    logic [7:0] h0, h1;
    int         cls;
  } vec_t;

  vec_t       tbl[5];
  logic [7:0] exp_wc;
  logic [3:0] m_pend[$];
  logic       m_valid;
  logic [7:0] m_code, m_wc;
  logic [7:0] ib;
  logic       exp_ready, hs;

  initial begin
    tbl[0] = '{8'h5B, 2'b00, 3'd0, 8'h55, 8'h2D, 8'h2D, 8'h55, 0};
    tbl[1] = '{8'hF0, 2'b00, 3'd0, 8'h00, 8'hFF, 8'hFF, 8'h00, 0};
    tbl[2] = '{8'h5B, 2'b01, 3'd2, 8'h51, 8'h29, 8'h29, 8'h51, 1};
    tbl[3] = '{8'h5B, 2'b10, 3'd7, 8'hD4, 8'hAC, 8'hAC, 8'hD4, 2};
    tbl[4] = '{8'h5B, 2'b11, 3'd5, 8'h55, 8'h2D, 8'h2D, 8'h55, 0};

    #12;
    chk("rst_out_code", out_code, 8'h00);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_word_count", word_count, 8'h00);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", in_ready, 1'b1);

    // Table: one byte per entry, sink always ready
    exp_wc = 8'h00;
    for (int i = 0; i < 5; i++) begin
      in_data = tbl[i].din; inj_mode = tbl[i].mode; inj_pos = tbl[i].pos;
      in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk($sformatf("tbl%0d_code0", i), out_code, tbl[i].exp0);
      chk($sformatf("tbl%0d_hf_code0", i), h_out_code, tbl[i].h0);
      chk($sformatf("tbl%0d_valid0", i), out_valid, 1'b1);
      chk($sformatf("tbl%0d_busy0", i), busy, 1'b1);
      chk($sformatf("tbl%0d_class", i), classify(out_code), tbl[i].cls);
      tick();
      chk($sformatf("tbl%0d_code1", i), out_code, tbl[i].exp1);
      chk($sformatf("tbl%0d_hf_code1", i), h_out_code, tbl[i].h1);
      tick();
      exp_wc = exp_wc + 8'd2;
      chk($sformatf("tbl%0d_valid_end", i), out_valid, 1'b0);
      chk($sformatf("tbl%0d_busy_end", i), busy, 1'b0);
      chk($sformatf("tbl%0d_wc", i), word_count, exp_wc);
    end
    inj_mode = 2'b00; inj_pos = 3'd0;

    // Back-to-back bytes
    in_data = 8'h5B; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk("b2b_ready_idle", in_ready, 1'b1);
    tick();
    chk("b2b_c0", out_code, 8'h55);
    chk("b2b_ready_first", in_ready, 1'b0);
    in_data = 8'hF0;
    tick();
    chk("b2b_c1", out_code, 8'h2D);
    chk("b2b_ready_second", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("b2b_c2", out_code, 8'h00);
    chk("b2b_ready_first2", in_ready, 1'b0);
    tick();
    chk("b2b_c3", out_code, 8'hFF);
    chk("b2b_valid_c3", out_valid, 1'b1);
    tick();
    exp_wc = exp_wc + 8'd4;
    chk("b2b_idle", out_valid, 1'b0);
    chk("b2b_wc", word_count, exp_wc);

    // Backpressure, including an injection change while the codeword is held
    in_data = 8'h5B; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    inj_mode = 2'b01; inj_pos = 3'd0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_code", out_code, 8'h55);
      chk("bp_hold_ready", in_ready, 1'b0);
      chk("bp_hold_wc", word_count, exp_wc);
      tick();
    end
    inj_mode = 2'b00; out_ready = 1'b1;
    tick();
    exp_wc = exp_wc + 8'd1;
    chk("bp_release_code", out_code, 8'h2D);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hF0;
    #1 chk("bp_second_ready", in_ready, 1'b0);
    tick();
    chk("bp_second_hold", out_code, 8'h2D);
    chk("bp_second_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    #1 chk("bp_second_ready_on", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    exp_wc = exp_wc + 8'd1;
    chk("bp_next_c0", out_code, 8'h00);
    tick();
    chk("bp_next_c1", out_code, 8'hFF);
    tick();
    exp_wc = exp_wc + 8'd2;
    chk("bp_wc", word_count, exp_wc);
    chk("bp_idle", out_valid, 1'b0);

    // Reset mid-byte
    in_data = 8'h5B; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("mr_c0", out_code, 8'h55);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_code", out_code, 8'h00);
    chk("mr_valid", out_valid, 1'b0);
    chk("mr_busy", busy, 1'b0);
    chk("mr_wc", word_count, 8'h00);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr_no_second", out_valid, 1'b0);
      chk("mr_ready", in_ready, 1'b1);
    end

    // 256 codewords back-to-back: word_count wraps
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      in_data = 8'($urandom);
      tick();
    end
    chk("wrap_wc_255", word_count, 8'hFF);
    in_valid = 1'b0;
    tick();
    chk("wrap_wc_0", word_count, 8'h00);
    chk("wrap_idle", out_valid, 1'b0);

    // Randomized traffic against the reference model
    m_valid = 1'b0; m_code = 8'h00; m_wc = 8'h00;
    m_pend.delete();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      inj_mode  = 2'($urandom);
      inj_pos   = 3'($urandom);
      #1;
      exp_ready = !m_valid || (m_pend.size() == 0 && out_ready);
      chk("rnd_in_ready", in_ready, exp_ready);
      chk("rnd_out_valid", out_valid, m_valid);
      if (m_valid) chk("rnd_out_code", out_code, m_code);
      chk("rnd_wc", word_count, m_wc);
      chk("rnd_busy", busy, m_valid);
      hs = m_valid && out_ready;
      if (hs) m_wc = m_wc + 8'd1;
      if (!m_valid || hs) begin
        if (m_pend.size() != 0) begin
          m_code = ref_enc(m_pend.pop_front()) ^ ref_mask(inj_mode, inj_pos);
          m_valid = 1'b1;
        end else if (in_valid) begin
          ib = in_data;
          m_pend.push_back(ib[7:4]);
          m_code = ref_enc(ib[3:0]) ^ ref_mask(inj_mode, inj_pos);
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
